// File: rtl/ceespu_int_controller_pkg.sv
// Shared constants for the ceespu interrupt controller: register map,
// source count and FSM state encoding.
package ceespu_int_controller_pkg;

    localparam int INTC_NUM_SRC = 4;

    localparam logic [1:0] INTC_ADDR_ENABLE  = 2'd0;
    localparam logic [1:0] INTC_ADDR_PENDING = 2'd1;
    localparam logic [1:0] INTC_ADDR_STATUS  = 2'd2;
    localparam logic [1:0] INTC_ADDR_TRIGGER = 2'd3;

    typedef enum logic [1:0] {
        INTC_IDLE = 2'd0,
        INTC_REQ  = 2'd1,
        INTC_GAP  = 2'd2
    } intc_state_t;

endpackage

// File: rtl/ceespu_irq_sync.sv
// One interrupt line: multi-flop synchronizer followed by either a rising
// edge detector or a plain level pass-through, selected by LEVEL.
module ceespu_irq_sync #(
    parameter int SYNC_STAGES = 2,
    parameter bit LEVEL       = 1'b0
) (
    input  logic I_clk,
    input  logic I_rst,
    input  logic I_irq,
    output logic O_set
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   w_sync_out;

    assign w_sync_out = r_sync[SYNC_STAGES-1];

    // Shift the asynchronous line through the chain; r_prev remembers the
    // previous synchronized value for edge detection.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], I_irq};
            r_prev <= w_sync_out;
        end
    end

    // Level sources request every cycle the line is high; edge sources only
    // on the first synchronized cycle after a 0->1 transition.
    assign O_set = LEVEL ? w_sync_out : (w_sync_out & ~r_prev);

endmodule

// File: rtl/ceespu_int_controller.sv
// Interrupt controller: captures four request lines into a pending register,
// masks them with a software enable, and holds one prioritized request to the
// decode stage until it is acknowledged. A 4-word register window on the data
// bus exposes enable, pending, status and a software trigger.
module ceespu_int_controller
    import ceespu_int_controller_pkg::*;
#(
    parameter int                      SYNC_STAGES = 2,
    parameter logic [INTC_NUM_SRC-1:0] LEVEL_MASK  = 4'b0000
) (
    input  logic        I_clk,
    input  logic        I_rst,
    input  logic [3:0]  I_irq,
    input  logic        I_int_ack,
    input  logic        I_memE,
    input  logic        I_memWe,
    input  logic [1:0]  I_addr,
    input  logic [31:0] I_data,
    output logic [31:0] O_data,
    output logic        O_int,
    output logic [1:0]  O_int_vector
);

    intc_state_t             r_state;
    logic [INTC_NUM_SRC-1:0] r_pending;
    logic [INTC_NUM_SRC-1:0] r_enable;
    logic [1:0]              r_vec;
    logic                    r_int;
    logic [31:0]             r_data;

    logic [INTC_NUM_SRC-1:0] w_hw_set;
    logic [INTC_NUM_SRC-1:0] w_pending_next;
    logic [INTC_NUM_SRC-1:0] w_req;
    logic [1:0]              w_req_vec;
    logic                    w_req_any;
    logic                    w_wr;
    logic                    w_rd;
    logic                    w_ack_take;
    logic                    w_unused_data;

    assign w_wr       = I_memE &  I_memWe;
    assign w_rd       = I_memE & ~I_memWe;
    assign w_ack_take = I_int_ack && (r_state == INTC_REQ);

    // Only the low nibble of write data is architecturally meaningful.
    assign w_unused_data = ^I_data[31:INTC_NUM_SRC];

    // Per-line synchronizer and edge/level detection.
    genvar gi;
    generate
        for (gi = 0; gi < INTC_NUM_SRC; gi++) begin : g_sync
            ceespu_irq_sync #(
                .SYNC_STAGES (SYNC_STAGES),
                .LEVEL       (LEVEL_MASK[gi])
            ) u_sync (
                .I_clk (I_clk),
                .I_rst (I_rst),
                .I_irq (I_irq[gi]),
                .O_set (w_hw_set[gi])
            );
        end
    endgenerate

    // Pending next-state: clears (ack, W1C) are applied first so that a
    // simultaneous hardware or TRIGGER set always wins.
    always_comb begin
        w_pending_next = r_pending;
        if (w_ack_take) begin
            w_pending_next[r_vec] = 1'b0;
        end
        if (w_wr && (I_addr == INTC_ADDR_PENDING)) begin
            w_pending_next = w_pending_next & ~I_data[INTC_NUM_SRC-1:0];
        end
        w_pending_next = w_pending_next | w_hw_set;
        if (w_wr && (I_addr == INTC_ADDR_TRIGGER)) begin
            w_pending_next = w_pending_next | I_data[INTC_NUM_SRC-1:0];
        end
    end

    // Priority encoder: lowest set index of the enabled pending requests.
    always_comb begin
        w_req     = r_pending & r_enable;
        w_req_any = |w_req;
        w_req_vec = 2'd0;
        for (int i = INTC_NUM_SRC - 1; i >= 0; i--) begin
            if (w_req[i]) begin
                w_req_vec = 2'(i);
            end
        end
    end

    // Pending and enable registers.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            r_pending <= '0;
            r_enable  <= '0;
        end else begin
            r_pending <= w_pending_next;
            if (w_wr && (I_addr == INTC_ADDR_ENABLE)) begin
                r_enable <= I_data[INTC_NUM_SRC-1:0];
            end
        end
    end

    // Registered read port; holds its value until the next read.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            r_data <= '0;
        end else if (w_rd) begin
            case (I_addr)
                INTC_ADDR_ENABLE:  r_data <= {28'd0, r_enable};
                INTC_ADDR_PENDING: r_data <= {28'd0, r_pending};
                INTC_ADDR_STATUS:  r_data <= {28'd0,
                                              (r_state == INTC_GAP),
                                              (r_state == INTC_REQ),
                                              r_vec};
                default:           r_data <= '0;
            endcase
        end
    end

    // Request handshake FSM. Once in REQ the request is held regardless of
    // mask or pending changes, since decode may already have taken it. GAP
    // forces one low cycle on O_int; if more work is waiting at that point it
    // goes straight back to REQ so the low gap is exactly one cycle.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            r_state <= INTC_IDLE;
            r_vec   <= 2'd0;
            r_int   <= 1'b0;
        end else begin
            case (r_state)
                INTC_IDLE: begin
                    if (w_req_any) begin
                        r_state <= INTC_REQ;
                        r_vec   <= w_req_vec;
                        r_int   <= 1'b1;
                    end
                end
                INTC_REQ: begin
                    if (I_int_ack) begin
                        r_state <= INTC_GAP;
                        r_int   <= 1'b0;
                    end
                end
                INTC_GAP: begin
                    if (w_req_any) begin
                        r_state <= INTC_REQ;
                        r_vec   <= w_req_vec;
                        r_int   <= 1'b1;
                    end else begin
                        r_state <= INTC_IDLE;
                    end
                end
                default: begin
                    r_state <= INTC_IDLE;
                    r_int   <= 1'b0;
                end
            endcase
        end
    end

    assign O_int        = r_int;
    assign O_int_vector = r_vec;
    assign O_data       = r_data;

endmodule

// File: tb/tb_ceespu_int_controller.sv
// Directed bench for ceespu_int_controller: a table of register-window
// accesses followed by hand-written handshake sequences.
module tb_ceespu_int_controller;

    logic        I_clk;
    logic        I_rst;
    logic [3:0]  I_irq;
    logic        I_int_ack;
    logic        I_memE;
    logic        I_memWe;
    logic [1:0]  I_addr;
    logic [31:0] I_data;
    logic [31:0] O_data;
    logic        O_int;
    logic [1:0]  O_int_vector;

    int pass_cnt;
    int total_cnt;

    localparam logic [1:0] A_EN  = 2'd0;
    localparam logic [1:0] A_PND = 2'd1;
    localparam logic [1:0] A_ST  = 2'd2;
    localparam logic [1:0] A_TRG = 2'd3;

    ceespu_int_controller #(
        .SYNC_STAGES (2),
        .LEVEL_MASK  (4'b0001)
    ) dut (
        .I_clk        (I_clk),
        .I_rst        (I_rst),
        .I_irq        (I_irq),
        .I_int_ack    (I_int_ack),
        .I_memE       (I_memE),
        .I_memWe      (I_memWe),
        .I_addr       (I_addr),
        .I_data       (I_data),
        .O_data       (O_data),
        .O_int        (O_int),
        .O_int_vector (O_int_vector)
    );

    initial I_clk = 1'b0;
    always #5 I_clk = ~I_clk;

    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge I_clk);
        #1;
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
        I_memE = 1'b1; I_memWe = 1'b1; I_addr = a; I_data = d;
        tick();
        I_memE = 1'b0; I_memWe = 1'b0; I_data = '0;
    endtask

    task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
        I_memE = 1'b1; I_memWe = 1'b0; I_addr = a;
        tick();
        I_memE = 1'b0;
        d = O_data;
    endtask

    task automatic ack();
        I_int_ack = 1'b1;
        tick();
        I_int_ack = 1'b0;
    endtask

    // Wait (bounded) for O_int; returns the number of edges observed.
    task automatic wait_int(input int start, output int n);
        n = start;
        while (!O_int && n < 20) begin
            tick();
            n++;
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] last_rd;
        int          n;

        pass_cnt = 0; total_cnt = 0;
        I_rst = 1'b1; I_irq = '0; I_int_ack = 1'b0;
        I_memE = 1'b0; I_memWe = 1'b0; I_addr = '0; I_data = '0;

        // Register-window vectors; all with the FSM idle (enable ends at 0).
        tbl[0]  = '{1'b1, A_EN,  32'h0000000A, 32'h0};
        tbl[1]  = '{1'b0, A_EN,  32'h0,        32'hA};
        tbl[2]  = '{1'b1, A_EN,  32'hFFFFFFFF, 32'h0};
        tbl[3]  = '{1'b0, A_EN,  32'h0,        32'hF};
        tbl[4]  = '{1'b0, A_TRG, 32'h0,        32'h0};
        tbl[5]  = '{1'b1, A_EN,  32'h0,        32'h0};
        tbl[6]  = '{1'b0, A_EN,  32'h0,        32'h0};
        tbl[7]  = '{1'b1, A_TRG, 32'h6,        32'h0};
        tbl[8]  = '{1'b0, A_PND, 32'h0,        32'h6};
        tbl[9]  = '{1'b0, A_ST,  32'h0,        32'h0};
        tbl[10] = '{1'b1, A_PND, 32'h2,        32'h0};
        tbl[11] = '{1'b0, A_PND, 32'h0,        32'h4};
        tbl[12] = '{1'b1, A_PND, 32'hFFFFFFFF, 32'h0};
        tbl[13] = '{1'b0, A_PND, 32'h0,        32'h0};

        tick(); tick();
        chk("rst_int", {31'd0, O_int}, 32'd0);
        chk("rst_vec", {30'd0, O_int_vector}, 32'd0);
        chk("rst_data", O_data, 32'd0);
        I_rst = 1'b0;
        tick();

        // Table-driven register accesses.
        last_rd = 32'h0;
        for (int i = 0; i < 14; i++) begin
            if (tbl[i].we) begin
                reg_write(tbl[i].addr, tbl[i].wdata);
                $display("vec %0d: write addr %0d data 0x%0h", i, tbl[i].addr, tbl[i].wdata);
                chk("data_hold", O_data, last_rd);
            end else begin
                reg_read(tbl[i].addr, rd);
                $display("vec %0d: read addr %0d -> 0x%0h", i, tbl[i].addr, rd);
                chk($sformatf("tbl_rd%0d", i), rd, tbl[i].exp);
                last_rd = tbl[i].exp;
            end
        end

        // 1: edge source 2, one-cycle pulse, enable only source 2.
        reg_write(A_EN, 32'h4);
        I_irq[2] = 1'b1;
        tick();
        I_irq[2] = 1'b0;
        wait_int(1, n);
        chk("t1_latency", n, 32'd4);
        chk("t1_vec", {30'd0, O_int_vector}, 32'd2);
        tick(); tick(); tick();
        chk("t1_hold", {31'd0, O_int}, 32'd1);
        reg_read(A_ST, rd);
        chk("t1_status_req", rd, 32'h6);
        ack();
        chk("t1_gap", {31'd0, O_int}, 32'd0);
        tick();
        chk("t1_idle", {31'd0, O_int}, 32'd0);
        reg_read(A_PND, rd);
        chk("t1_pending", rd, 32'h0);
        $display("seq 1: edge source 2 served");

        // 2: trigger two sources, served in priority order with one low cycle.
        reg_write(A_EN, 32'hF);
        reg_write(A_TRG, 32'hA);
        chk("t2_n1", {31'd0, O_int}, 32'd0);
        tick();
        chk("t2_n2", {31'd0, O_int}, 32'd1);
        chk("t2_vec1", {30'd0, O_int_vector}, 32'd1);
        ack();
        chk("t2_gap", {31'd0, O_int}, 32'd0);
        tick();
        chk("t2_req3", {31'd0, O_int}, 32'd1);
        chk("t2_vec3", {30'd0, O_int_vector}, 32'd3);
        ack();
        tick();
        chk("t2_idle", {31'd0, O_int}, 32'd0);
        reg_read(A_PND, rd);
        chk("t2_pending", rd, 32'h0);
        $display("seq 2: triggered vectors 1 and 3 served");

        // 3: request is not withdrawn by masking or W1C while in REQ.
        reg_write(A_TRG, 32'h1);
        tick();
        chk("t3_req", {31'd0, O_int}, 32'd1);
        reg_write(A_EN, 32'h0);
        reg_write(A_PND, 32'h1);
        chk("t3_hold", {31'd0, O_int}, 32'd1);
        chk("t3_vec", {30'd0, O_int_vector}, 32'd0);
        reg_read(A_PND, rd);
        chk("t3_pending", rd, 32'h0);
        chk("t3_hold2", {31'd0, O_int}, 32'd1);
        ack();
        tick(); tick();
        chk("t3_idle", {31'd0, O_int}, 32'd0);
        reg_read(A_ST, rd);
        chk("t3_status", rd, 32'h0);
        $display("seq 3: masked request held until ack");

        // 4: level source 0 re-requests while held high.
        reg_write(A_EN, 32'hF);
        I_irq[0] = 1'b1;
        tick();
        wait_int(1, n);
        chk("t4_latency", n, 32'd4);
        chk("t4_vec", {30'd0, O_int_vector}, 32'd0);
        ack();
        chk("t4_gap", {31'd0, O_int}, 32'd0);
        tick();
        chk("t4_rereq", {31'd0, O_int}, 32'd1);
        I_irq[0] = 1'b0;
        tick(); tick(); tick(); tick();
        ack();
        tick(); tick();
        chk("t4_idle", {31'd0, O_int}, 32'd0);
        reg_read(A_PND, rd);
        chk("t4_pending", rd, 32'h0);
        $display("seq 4: level source 0 re-request");

        // 5: hardware set beats W1C in the same cycle; ack in IDLE ignored.
        reg_write(A_EN, 32'h0);
        I_irq[2] = 1'b1;
        tick(); tick();
        reg_write(A_PND, 32'h4);
        reg_read(A_PND, rd);
        chk("t5_set_wins", rd, 32'h4);
        reg_write(A_PND, 32'h4);
        reg_read(A_PND, rd);
        chk("t5_w1c", rd, 32'h0);
        I_irq[2] = 1'b0;
        reg_write(A_TRG, 32'h1);
        ack();
        reg_read(A_PND, rd);
        chk("t5_ack_idle_pnd", rd, 32'h1);
        reg_read(A_ST, rd);
        chk("t5_ack_idle_st", rd, 32'h0);
        reg_write(A_PND, 32'h1);
        $display("seq 5: same-cycle set/clear and idle ack");

        // 6: asynchronous reset in REQ.
        reg_write(A_EN, 32'hF);
        reg_write(A_TRG, 32'h4);
        tick();
        chk("t6_req", {31'd0, O_int}, 32'd1);
        #2 I_rst = 1'b1;
        #1 chk("t6_async", {31'd0, O_int}, 32'd0);
        tick();
        I_rst = 1'b0;
        tick();
        reg_read(A_EN, rd);
        chk("t6_enable", rd, 32'h0);
        reg_read(A_PND, rd);
        chk("t6_pending", rd, 32'h0);
        chk("t6_int", {31'd0, O_int}, 32'd0);
        $display("seq 6: async reset mid-request");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
